imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 208 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pipe
//  Description : RISC-V immediate generator with a two-entry registered
//                output stage (OUT + SKID) and valid/ready handshaking on
//                both sides. The upstream ready is a pure register, so there
//                is no combinational path from downstream ready to upstream.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,   // datapath width, 32 or 64
    parameter int TAG_W = 8     // sideband tag width
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Flush,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [31:0]      i_Instr,
    input  logic [TAG_W-1:0] i_Tag,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [XLEN-1:0]  o_ImmData,
    output logic [2:0]       o_ImmType,
    output logic [TAG_W-1:0] o_Tag
);

    // ------------------------------------------------------------------------
    // Opcodes and immediate format codes
    // ------------------------------------------------------------------------
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;
    localparam logic [2:0] TYPE_Z    = 3'd6;

    // OP-IMM-32 only exists on RV64
    localparam bit HAS_OP_IMM_32 = (XLEN == 64);

    // ------------------------------------------------------------------------
    // Immediate field extraction (signed fields sign-extend on the size cast)
    // ------------------------------------------------------------------------
    logic [6:0]         opcode;
    logic signed [11:0] fld_i;
    logic signed [11:0] fld_s;
    logic signed [12:0] fld_b;
    logic signed [20:0] fld_j;
    logic signed [31:0] fld_u;
    logic [4:0]         fld_z;
    logic               zimm_sel;

    assign opcode   = i_Instr[6:0];
    assign fld_i    = i_Instr[31:20];
    assign fld_s    = {i_Instr[31:25], i_Instr[11:7]};
    assign fld_b    = {i_Instr[31], i_Instr[7], i_Instr[30:25], i_Instr[11:8], 1'b0};
    assign fld_j    = {i_Instr[31], i_Instr[19:12], i_Instr[20], i_Instr[30:21], 1'b0};
    assign fld_u    = {i_Instr[31:12], 12'h000};
    assign fld_z    = i_Instr[19:15];
    assign zimm_sel = i_Instr[14];       // funct3[2]: immediate CSR variants

    // ------------------------------------------------------------------------
    // Decode happens before capture so the stored entry is already final
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;

    // Select format and build the extended immediate from the opcode
    always_comb begin
        dec_imm  = '0;
        dec_type = TYPE_NONE;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                dec_type = TYPE_I;
                dec_imm  = XLEN'(fld_i);
            end
            OPC_OP_IMM_32: begin
                if (HAS_OP_IMM_32) begin
                    dec_type = TYPE_I;
                    dec_imm  = XLEN'(fld_i);
                end
            end
            OPC_STORE: begin
                dec_type = TYPE_S;
                dec_imm  = XLEN'(fld_s);
            end
            OPC_BRANCH: begin
                dec_type = TYPE_B;
                dec_imm  = XLEN'(fld_b);
            end
            OPC_JAL: begin
                dec_type = TYPE_J;
                dec_imm  = XLEN'(fld_j);
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_type = TYPE_U;
                dec_imm  = XLEN'(fld_u);
            end
            OPC_SYSTEM: begin
                // Register-form CSR ops still report Z with a zero immediate
                dec_type = TYPE_Z;
                dec_imm  = zimm_sel ? XLEN'(fld_z) : '0;
            end
            default: begin
                dec_type = TYPE_NONE;
                dec_imm  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Two-entry output stage
    // ------------------------------------------------------------------------
    logic             out_valid;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_type;
    logic [TAG_W-1:0] out_tag;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_type;
    logic [TAG_W-1:0] skid_tag;

    logic             ready_q;
    logic             accept;
    logic             load_out;

    // ready_q is a register, so accept never depends on i_Ready this cycle.
    // SKID can only be full while ready_q is low, so accept and a SKID drain
    // into OUT are mutually exclusive.
    assign accept   = i_Valid && ready_q;
    assign load_out = !out_valid || i_Ready;

    // Valid bits and the registered upstream ready
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else if (i_Flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (load_out) begin
            out_valid  <= skid_valid || accept;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (accept) begin
            // OUT is stalled: park the new entry and stop accepting
            skid_valid <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            ready_q    <= !skid_valid;
        end
    end

    // OUT payload: refilled from SKID first to keep FIFO order, else from input
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            out_imm  <= '0;
            out_type <= TYPE_NONE;
            out_tag  <= '0;
        end else if (!i_Flush && load_out) begin
            if (skid_valid) begin
                out_imm  <= skid_imm;
                out_type <= skid_type;
                out_tag  <= skid_tag;
            end else if (accept) begin
                out_imm  <= dec_imm;
                out_type <= dec_type;
                out_tag  <= i_Tag;
            end
        end
    end

    // SKID payload: captures an accepted entry while OUT is stalled
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            skid_imm  <= '0;
            skid_type <= TYPE_NONE;
            skid_tag  <= '0;
        end else if (!i_Flush && !load_out && accept) begin
            skid_imm  <= dec_imm;
            skid_type <= dec_type;
            skid_tag  <= i_Tag;
        end
    end

    assign o_Ready   = ready_q;
    assign o_Valid   = out_valid;
    assign o_ImmData = out_imm;
    assign o_ImmType = out_type;
    assign o_Tag     = out_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_pipe
//  Description : Self-checking bench for imm_gen_pipe; an XLEN=32 and an
//                XLEN=64 instance share all inputs and are compared against
//                an arithmetic reference model and an entry queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  tag;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic [31:0] instr;
    logic [7:0]  tag;
    logic        rdy;

    logic        ready32, valid32, ready64, valid64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  type32, type64;
    logic [7:0]  tag32, tag64;

    int checks = 0;
    int errors = 0;
    entry_t q[$];
    bit just_reset;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Flush(flush), .i_Valid(valid),
        .o_Ready(ready32), .i_Instr(instr), .i_Tag(tag), .o_Valid(valid32),
        .i_Ready(rdy), .o_ImmData(imm32), .o_ImmType(type32), .o_Tag(tag32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Flush(flush), .i_Valid(valid),
        .o_Ready(ready64), .i_Instr(instr), .i_Tag(tag), .o_Valid(valid64),
        .i_Ready(rdy), .o_ImmData(imm64), .o_ImmType(type64), .o_Tag(tag64));

    // Reference format code from the opcode table
    function automatic int exp_type(input logic [31:0] ins, input int xlen);
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: return 1;
            7'b0011011:                         return (xlen == 64) ? 1 : 0;
            7'b0100011:                         return 2;
            7'b1100011:                         return 3;
            7'b0110111, 7'b0010111:             return 4;
            7'b1101111:                         return 5;
            7'b1110011:                         return 6;
            default:                            return 0;
        endcase
    endfunction

    // Reference immediate: weighted field sums, signed by two's-complement wrap
    function automatic logic [63:0] exp_imm(input logic [31:0] ins, input int xlen);
        longint v;
        v = 0;
        case (exp_type(ins, xlen))
            1: begin
                v = ins[31:20];
                if (v >= 2048) v = v - 4096;
            end
            2: begin
                v = ins[31:25] * 32 + ins[11:7];
                if (v >= 2048) v = v - 4096;
            end
            3: begin
                v = ins[31] * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
                if (v >= 4096) v = v - 8192;
            end
            4: begin
                v = ins[31:12] * 4096;
                if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
            end
            5: begin
                v = ins[31] * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
                if (v >= 1048576) v = v - 2097152;
            end
            6: v = ins[14] ? longint'(ins[19:15]) : 0;
            default: v = 0;
        endcase
        if (xlen == 32) return {32'h0, v[31:0]};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Compare both instances against the model's held entries
    task automatic check_state();
        logic exp_rdy;
        exp_rdy = (q.size() < 2) && !just_reset;
        chk("ready32", ready32, exp_rdy);
        chk("ready64", ready64, exp_rdy);
        chk("valid32", valid32, q.size() > 0);
        chk("valid64", valid64, q.size() > 0);
        if (q.size() > 0) begin
            chk("imm32",  imm32,  exp_imm(q[0].instr, 32));
            chk("type32", type32, exp_type(q[0].instr, 32));
            chk("tag32",  tag32,  q[0].tag);
            chk("imm64",  imm64,  exp_imm(q[0].instr, 64));
            chk("type64", type64, exp_type(q[0].instr, 64));
            chk("tag64",  tag64,  q[0].tag);
        end
    endtask

    // One clock: check, then advance the model by the handshakes of this cycle
    task automatic cycle();
        bit acc, pop, fl, run;
        #1;
        check_state();
        run = rst_n;
        fl  = flush;
        acc = valid && (q.size() < 2) && !just_reset;
        pop = rdy && (q.size() > 0);
        @(posedge clk);
        if (run) begin
            if (fl) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back('{instr: instr, tag: tag});
            end
            just_reset = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] t, input logic r);
        valid = v;
        instr = ins;
        tag   = t;
        rdy   = r;
    endtask

    task automatic rand_step(input int flush_pct);
        logic [6:0] ops [0:10];
        int idx;
        logic [31:0] ins;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011, 7'b1101111,
                7'b0110111, 7'b0010111, 7'b1110011, 7'b0011011, 7'b0110011};
        idx = $urandom_range(0, 11);
        ins = $urandom;
        if (idx < 11) ins[6:0] = ops[idx];
        drive($urandom_range(0, 3) != 0, ins, 8'($urandom), $urandom_range(0, 2) != 0);
        flush = ($urandom_range(0, 99) < flush_pct);
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; just_reset = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset values
        #1;
        chk("rst_valid", valid32, 1'b0);
        chk("rst_ready", ready32, 1'b0);
        chk("rst_imm",   imm32,   32'h0);
        chk("rst_type",  type32,  3'd0);
        chk("rst_tag",   tag32,   8'h0);
        chk("rst_valid64", valid64, 1'b0);
        chk("rst_ready64", ready64, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();                                 // ready rises at this edge
        chk("ready_after_rst", ready32, 1'b1);

        // Basic I-type
        drive(1'b1, 32'hFFF00093, 8'h11, 1'b1); cycle();
        chk("i_imm", imm32, 32'hFFFFFFFF);
        chk("i_type", type32, 3'd1);
        chk("i_tag", tag32, 8'h11);

        // Back-to-back J, U, Z
        drive(1'b1, 32'hFFDFF06F, 8'h21, 1'b1); cycle();
        chk("j_imm", imm32, 32'hFFFFFFFC); chk("j_type", type32, 3'd5);
        drive(1'b1, 32'h123450B7, 8'h22, 1'b1); cycle();
        chk("u_imm", imm32, 32'h12345000); chk("u_type", type32, 3'd4);
        drive(1'b1, 32'h000FD073, 8'h23, 1'b1); cycle();
        chk("z_imm", imm32, 32'h0000001F); chk("z_type", type32, 3'd6);

        // XLEN-dependent cases
        drive(1'b1, 32'h800000B7, 8'h31, 1'b1); cycle();
        chk("u64_imm", imm64, 64'hFFFFFFFF80000000); chk("u64_type", type64, 3'd4);
        drive(1'b1, 32'h0010009B, 8'h32, 1'b1); cycle();
        chk("w64_imm", imm64, 64'h1); chk("w64_type", type64, 3'd1);
        chk("w32_imm", imm32, 32'h0); chk("w32_type", type32, 3'd0);
        drive(1'b0, 32'h0, 8'h0, 1'b1); cycle();

        // Backpressure: A in OUT, B in SKID, C stalled
        drive(1'b1, 32'h00500513, 8'hA1, 1'b0); cycle();
        drive(1'b1, 32'hFE010113, 8'hB2, 1'b0); cycle();
        drive(1'b1, 32'h00112623, 8'hC3, 1'b0); cycle(); cycle();
        chk("bp_ready", ready32, 1'b0); chk("bp_tag_a", tag32, 8'hA1);
        rdy = 1'b1; cycle();
        chk("bp_tag_b", tag32, 8'hB2); chk("bp_valid_b", valid32, 1'b1);
        cycle();
        chk("bp_tag_c", tag32, 8'hC3);
        valid = 1'b0; cycle(); cycle();
        chk("bp_drained", valid32, 1'b0);

        // Flush with both entries full and a same-cycle input
        drive(1'b1, 32'h00A00093, 8'hD1, 1'b0); cycle();
        drive(1'b1, 32'h00B00093, 8'hD2, 1'b0); cycle();
        drive(1'b1, 32'h00C00093, 8'hEE, 1'b0); flush = 1'b1; cycle();
        flush = 1'b0; valid = 1'b0;
        chk("fl_valid", valid32, 1'b0); chk("fl_ready", ready32, 1'b1);
        rdy = 1'b1; repeat (3) cycle();

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) rand_step(4);

        // Asynchronous reset between edges while holding two entries
        drive(1'b0, 32'h0, 8'h0, 1'b1); repeat (2) cycle();
        drive(1'b1, 32'h7FF00093, 8'h51, 1'b0); cycle();
        drive(1'b1, 32'h80000037, 8'h52, 1'b0); cycle();
        valid = 1'b0;
        chk("ar_pre_valid", valid32, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", valid32, 1'b0); chk("ar_ready", ready32, 1'b0);
        chk("ar_imm", imm32, 32'h0); chk("ar_type", type32, 3'd0); chk("ar_tag", tag32, 8'h0);
        chk("ar_valid64", valid64, 1'b0); chk("ar_imm64", imm64, 64'h0);
        q.delete();
        just_reset = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) rand_step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
